// File: rtl/draw_menu_sel.sv
// Menu screen renderer: border, background and N stacked buttons with a blinking
// keyboard-driven selection. Timing signals and colour leave one cycle after entry.
module draw_menu_sel #(
  parameter int          H_ACTIVE     = 1024,
  parameter int          V_ACTIVE     = 768,
  parameter int          BORDER_W     = 3,
  parameter int          N_BUTTONS    = 3,
  parameter int          SEL_W        = 3,
  parameter int          BTN_X        = 412,
  parameter int          BTN_W        = 200,
  parameter int          BTN_Y0       = 200,
  parameter int          BTN_H        = 80,
  parameter int          BTN_PITCH    = 120,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] C_BORDER     = 12'hf00,
  parameter logic [11:0] C_BG         = 12'h888,
  parameter logic [11:0] C_BTN        = 12'h444,
  parameter logic [11:0] C_HL         = 12'hff0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  input  logic             key_up,
  input  logic             key_down,
  input  logic             key_enter,
  output logic [10:0]      hcount_out,
  output logic [9:0]       vcount_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output logic [11:0]      rgb_out,
  output logic [SEL_W-1:0] sel_idx,
  output logic             choice_valid,
  output logic [SEL_W-1:0] choice
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] frame_cnt;
  logic             phase;
  logic             vblnk_prev;
  logic             tick;
  logic             move_up;
  logic             move_down;
  logic [SEL_W-1:0] sel_next;
  logic [11:0]      rgb_p0;

  // Buttons never overlap (pitch >= height), so at most one loop iteration hits.
  function automatic logic [11:0] pixel_colour(
    input logic [10:0]      h,
    input logic [9:0]       v,
    input logic             blank,
    input logic [SEL_W-1:0] sel,
    input logic             ph
  );
    logic [15:0] hx;
    logic [15:0] vx;
    logic [15:0] top;
    logic [11:0] c;
    hx = {5'd0, h};
    vx = {6'd0, v};
    c  = C_BG;
    if (blank) begin
      c = 12'h000;
    end else if (hx < 16'(BORDER_W) || hx >= 16'(H_ACTIVE - BORDER_W) ||
                 vx < 16'(BORDER_W) || vx >= 16'(V_ACTIVE - BORDER_W)) begin
      c = C_BORDER;
    end else if (hx >= 16'(BTN_X) && hx < 16'(BTN_X + BTN_W)) begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        top = 16'(BTN_Y0 + i * BTN_PITCH);
        if (vx >= top && vx < top + 16'(BTN_H))
          c = (SEL_W'(i) == sel && !ph) ? C_HL : C_BTN;
      end
    end
    return c;
  endfunction

  assign tick      = vblnk_in & ~vblnk_prev;
  assign move_up   = key_up & ~key_down;
  assign move_down = key_down & ~key_up;

  always_comb begin
    sel_next = sel_idx;
    if (move_up)
      sel_next = (sel_idx == '0) ? SEL_W'(N_BUTTONS - 1) : sel_idx - SEL_W'(1);
    else if (move_down)
      sel_next = (sel_idx == SEL_W'(N_BUTTONS - 1)) ? '0 : sel_idx + SEL_W'(1);
  end

  assign rgb_p0 = pixel_colour(hcount_in, vcount_in, hblnk_in | vblnk_in, sel_idx, phase);

  // Stage p0 -> p1: every output registered once
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out   <= '0;
      vcount_out   <= '0;
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
      hblnk_out    <= 1'b0;
      vblnk_out    <= 1'b0;
      rgb_out      <= '0;
      sel_idx      <= '0;
      choice_valid <= 1'b0;
      choice       <= '0;
      frame_cnt    <= '0;
      phase        <= 1'b0;
      vblnk_prev   <= 1'b0;
    end else begin
      hcount_out   <= hcount_in;
      vcount_out   <= vcount_in;
      hsync_out    <= hsync_in;
      vsync_out    <= vsync_in;
      hblnk_out    <= hblnk_in;
      vblnk_out    <= vblnk_in;
      rgb_out      <= rgb_p0;
      vblnk_prev   <= vblnk_in;
      sel_idx      <= sel_next;
      choice_valid <= key_enter;
      if (key_enter)
        choice <= sel_idx;
      // A selection move restarts the blink so the new button lights at once.
      if (move_up | move_down) begin
        frame_cnt <= '0;
        phase     <= 1'b0;
      end else if (tick) begin
        if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
